// File: rtl/matrix_pkg.sv
// Shared definitions for the rectangular matrix multiplier: controller states,
// memory access type codes, matrix select codes and mode bit positions.
package matrix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_A = 3'd1,
        ST_FETCH_B = 3'd2,
        ST_FETCH_C = 3'd3,
        ST_MAC     = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    // Memory access granularity (out_type)
    localparam logic [1:0] TYPE_CELL = 2'b00;
    localparam logic [1:0] TYPE_ROW  = 2'b01;
    localparam logic [1:0] TYPE_COL  = 2'b10;

    // Matrix select (out_matrix)
    localparam logic [1:0] MAT_A = 2'b00;
    localparam logic [1:0] MAT_B = 2'b01;
    localparam logic [1:0] MAT_C = 2'b10;

    // Bit positions inside in_mode
    localparam int MODE_ACC_BIT = 0;
    localparam int MODE_SAT_BIT = 1;

    // Counter width that stays at least one bit for single-entry ranges
    function automatic int safe_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/dot_product_mac.sv
// Signed dot-product accumulator: seeded once per cell, then one lane product
// is added per enabled cycle. result_o presents the clamped or truncated value
// of the sum including the product being added this cycle, so the controller
// can register it on the same edge the last lane is accumulated.
module dot_product_mac #(
    parameter int CELL_W  = 8,
    parameter int INNER_K = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [CELL_W-1:0] seed_i,
    input  logic              en_i,
    input  logic [CELL_W-1:0] a_i,
    input  logic [CELL_W-1:0] b_i,
    input  logic              sat_i,
    output logic [CELL_W-1:0] result_o
);

    // Wide enough for K full-scale products plus a full-scale seed
    localparam int ACC_W = 2 * CELL_W + $clog2(INNER_K) + 1;

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [2*CELL_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s;
    logic signed [ACC_W-1:0]    seed_ext_s;
    logic signed [ACC_W-1:0]    sum_s;

    // Clamp to the signed cell range when saturating, otherwise keep low bits
    function automatic logic [CELL_W-1:0] clamp_cell(input logic signed [ACC_W-1:0] value,
                                                     input logic sat);
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = {{(ACC_W-CELL_W+1){1'b0}}, {(CELL_W-1){1'b1}}};
        min_v = ~max_v;
        if (!sat) begin
            clamp_cell = value[CELL_W-1:0];
        end else if (value > max_v) begin
            clamp_cell = max_v[CELL_W-1:0];
        end else if (value < min_v) begin
            clamp_cell = min_v[CELL_W-1:0];
        end else begin
            clamp_cell = value[CELL_W-1:0];
        end
    endfunction

    // Signed lane product, sign-extended sum and accumulator next state
    always_comb begin
        prod_s     = $signed(a_i) * $signed(b_i);
        prod_ext_s = {{(ACC_W-2*CELL_W){prod_s[2*CELL_W-1]}}, prod_s};
        seed_ext_s = {{(ACC_W-CELL_W){seed_i[CELL_W-1]}}, seed_i};
        sum_s      = acc_q + prod_ext_s;
        if (load_i) begin
            acc_d = seed_ext_s;
        end else if (en_i) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end
        if (en_i) begin
            result_o = clamp_cell(sum_s, sat_i);
        end else begin
            result_o = clamp_cell(acc_q, sat_i);
        end
    end

    // Accumulator register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/rect_matrix_mult.sv
// Rectangular matrix multiplier controller: C[MxN] (+)= A[MxK] * B[KxN].
// Walks the result cell by cell, fetching an A row (reused across a row of C),
// a B column, optionally the old C cell, then runs K MAC cycles and writes.
// All memory-side outputs are registered from the next-state decode so they
// are glitch-free and line up with the state they belong to.
module rect_matrix_mult
    import matrix_pkg::*;
#(
    parameter int ROWS_M  = 4,
    parameter int INNER_K = 4,
    parameter int COLS_N  = 4,
    parameter int CELL_W  = 8,
    parameter int ADDR_W  = 8
) (
    input  logic                      in_clk,
    input  logic                      in_reset,
    input  logic                      in_ready,
    input  logic [1:0]                in_mode,
    input  logic [INNER_K*CELL_W-1:0] in_row_a,
    input  logic [INNER_K*CELL_W-1:0] in_col_b,
    input  logic [CELL_W-1:0]         in_cell_c,
    input  logic                      in_a_ready,
    input  logic                      in_b_ready,
    input  logic                      in_c_ready,
    input  logic                      out_ack,
    output logic [ADDR_W-1:0]         out_reg_address,
    output logic [1:0]                out_type,
    output logic [1:0]                out_matrix,
    output logic                      out_read_en,
    output logic                      out_write_en,
    output logic [CELL_W-1:0]         out_cell_c,
    output logic                      out_busy,
    output logic                      out_ready
);

    localparam int R_W = safe_clog2(ROWS_M);
    localparam int C_W = safe_clog2(COLS_N);
    localparam int K_W = safe_clog2(INNER_K);

    state_e                    state_q, state_d;
    logic [R_W-1:0]            r_q, r_d;
    logic [C_W-1:0]            c_q, c_d;
    logic [K_W-1:0]            k_q, k_d;
    logic [1:0]                mode_q, mode_d;
    logic [INNER_K*CELL_W-1:0] row_a_q, row_a_d;
    logic [INNER_K*CELL_W-1:0] col_b_q, col_b_d;

    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [1:0]                type_q, type_d;
    logic [1:0]                mat_q, mat_d;
    logic                      rd_en_q, rd_en_d;
    logic                      wr_en_q, wr_en_d;
    logic [CELL_W-1:0]         cell_q, cell_d;
    logic                      busy_q, busy_d;
    logic                      ready_q, ready_d;

    logic                      mac_load_s;
    logic                      mac_en_s;
    logic [CELL_W-1:0]         mac_seed_s;
    logic [CELL_W-1:0]         a_lane_s;
    logic [CELL_W-1:0]         b_lane_s;
    logic [CELL_W-1:0]         mac_result_s;

    // Lane currently fed into the MAC, lane 0 first
    always_comb begin
        a_lane_s = row_a_q[int'(k_q)*CELL_W +: CELL_W];
        b_lane_s = col_b_q[int'(k_q)*CELL_W +: CELL_W];
    end

    dot_product_mac #(
        .CELL_W  (CELL_W),
        .INNER_K (INNER_K)
    ) u_mac (
        .clk_i    (in_clk),
        .rst_i    (in_reset),
        .load_i   (mac_load_s),
        .seed_i   (mac_seed_s),
        .en_i     (mac_en_s),
        .a_i      (a_lane_s),
        .b_i      (b_lane_s),
        .sat_i    (mode_q[MODE_SAT_BIT]),
        .result_o (mac_result_s)
    );

    // Next-state, counter and capture logic, then outputs decoded from next state
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        mode_d     = mode_q;
        row_a_d    = row_a_q;
        col_b_d    = col_b_q;
        mac_load_s = 1'b0;
        mac_en_s   = 1'b0;
        mac_seed_s = '0;

        case (state_q)
            ST_IDLE: begin
                if (in_ready) begin
                    mode_d  = in_mode;
                    r_d     = '0;
                    c_d     = '0;
                    state_d = ST_FETCH_A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH_A: begin
                if (in_a_ready) begin
                    row_a_d = in_row_a;
                    state_d = ST_FETCH_B;
                end else begin
                    state_d = ST_FETCH_A;
                end
            end
            ST_FETCH_B: begin
                if (in_b_ready) begin
                    col_b_d = in_col_b;
                    k_d     = '0;
                    if (mode_q[MODE_ACC_BIT]) begin
                        state_d = ST_FETCH_C;
                    end else begin
                        mac_load_s = 1'b1;
                        state_d    = ST_MAC;
                    end
                end else begin
                    state_d = ST_FETCH_B;
                end
            end
            ST_FETCH_C: begin
                if (in_c_ready) begin
                    mac_load_s = 1'b1;
                    mac_seed_s = in_cell_c;
                    state_d    = ST_MAC;
                end else begin
                    state_d = ST_FETCH_C;
                end
            end
            ST_MAC: begin
                mac_en_s = 1'b1;
                if (k_q == K_W'(INNER_K - 1)) begin
                    k_d     = '0;
                    state_d = ST_WRITE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = ST_MAC;
                end
            end
            ST_WRITE: begin
                if (c_q != C_W'(COLS_N - 1)) begin
                    c_d     = c_q + 1'b1;
                    state_d = ST_FETCH_B;
                end else begin
                    c_d = '0;
                    if (r_q != R_W'(ROWS_M - 1)) begin
                        r_d     = r_q + 1'b1;
                        state_d = ST_FETCH_A;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        addr_d  = '0;
        type_d  = 2'b00;
        mat_d   = 2'b00;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        cell_d  = '0;
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
        ready_d = (state_d == ST_DONE);

        case (state_d)
            ST_FETCH_A: begin
                rd_en_d = 1'b1;
                type_d  = TYPE_ROW;
                mat_d   = MAT_A;
                addr_d  = ADDR_W'(int'(r_d) * INNER_K);
            end
            ST_FETCH_B: begin
                rd_en_d = 1'b1;
                type_d  = TYPE_COL;
                mat_d   = MAT_B;
                addr_d  = ADDR_W'(int'(c_d));
            end
            ST_FETCH_C: begin
                rd_en_d = 1'b1;
                type_d  = TYPE_CELL;
                mat_d   = MAT_C;
                addr_d  = ADDR_W'(int'(r_d) * COLS_N + int'(c_d));
            end
            ST_WRITE: begin
                wr_en_d = 1'b1;
                type_d  = TYPE_CELL;
                mat_d   = MAT_C;
                addr_d  = ADDR_W'(int'(r_d) * COLS_N + int'(c_d));
                cell_d  = mac_result_s;
            end
            default: begin
                rd_en_d = 1'b0;
            end
        endcase
    end

    // State, counters, captured operands and registered outputs
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            mode_q  <= 2'b00;
            row_a_q <= '0;
            col_b_q <= '0;
            addr_q  <= '0;
            type_q  <= 2'b00;
            mat_q   <= 2'b00;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            cell_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            row_a_q <= row_a_d;
            col_b_q <= col_b_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            mat_q   <= mat_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            cell_q  <= cell_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign out_reg_address = addr_q;
    assign out_type        = type_q;
    assign out_matrix      = mat_q;
    assign out_read_en     = rd_en_q;
    assign out_write_en    = wr_en_q;
    assign out_cell_c      = cell_q;
    assign out_busy        = busy_q;
    assign out_ready       = ready_q;

endmodule

// File: tb/tb_rect_matrix_mult.sv
// Directed bench for rect_matrix_mult with a scoreboard of expected C writes.
// Instance A: M=K=N=2, CELL_W=8. Instance B: M=2, K=3, N=2, CELL_W=16.
module tb_rect_matrix_mult;
    import matrix_pkg::*;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A signals
    logic        ready_a, ack_a, arr_a, brr_a, crr_a;
    logic [1:0]  mode_a;
    logic [15:0] row_a, colb_a;
    logic [7:0]  cellc_a, addr_a, cout_a;
    logic [1:0]  type_a, mat_a;
    logic        rd_a, wr_a, busy_a, done_a;

    // Instance B signals
    logic        ready_b, ack_b, arr_b, brr_b, crr_b;
    logic [1:0]  mode_b;
    logic [47:0] row_b, colb_b;
    logic [15:0] cellc_b, cout_b;
    logic [7:0]  addr_b;
    logic [1:0]  type_b, mat_b;
    logic        rd_b, wr_b, busy_b, done_b;

    rect_matrix_mult #(.ROWS_M(2), .INNER_K(2), .COLS_N(2), .CELL_W(8), .ADDR_W(8)) u_dut_a (
        .in_clk(clk), .in_reset(rst), .in_ready(ready_a), .in_mode(mode_a),
        .in_row_a(row_a), .in_col_b(colb_a), .in_cell_c(cellc_a),
        .in_a_ready(arr_a), .in_b_ready(brr_a), .in_c_ready(crr_a), .out_ack(ack_a),
        .out_reg_address(addr_a), .out_type(type_a), .out_matrix(mat_a),
        .out_read_en(rd_a), .out_write_en(wr_a), .out_cell_c(cout_a),
        .out_busy(busy_a), .out_ready(done_a));

    rect_matrix_mult #(.ROWS_M(2), .INNER_K(3), .COLS_N(2), .CELL_W(16), .ADDR_W(8)) u_dut_b (
        .in_clk(clk), .in_reset(rst), .in_ready(ready_b), .in_mode(mode_b),
        .in_row_a(row_b), .in_col_b(colb_b), .in_cell_c(cellc_b),
        .in_a_ready(arr_b), .in_b_ready(brr_b), .in_c_ready(crr_b), .out_ack(ack_b),
        .out_reg_address(addr_b), .out_type(type_b), .out_matrix(mat_b),
        .out_read_en(rd_b), .out_write_en(wr_b), .out_cell_c(cout_b),
        .out_busy(busy_b), .out_ready(done_b));

    // Memories: ma[row][k], mb[k][col], mc[row*N+col]
    logic signed [7:0]  ma [2][2];
    logic signed [7:0]  mb [2][2];
    logic signed [7:0]  mc [4];
    logic signed [15:0] ma2 [2][3];
    logic signed [15:0] mb2 [3][2];
    logic               rb_sel;
    int b_delay = 0;
    int b_cnt   = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    int   wr_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr_cnt_a = 0;
    int   wr_cnt_b = 0;
    logic       prev_b_wait = 1'b0;
    logic [7:0] prev_b_addr = 8'h00;

    // Zero-wait memory model responding to the current request
    always_comb begin
        row_a   = {ma[addr_a[1]][1], ma[addr_a[1]][0]};
        colb_a  = {mb[1][addr_a[0]], mb[0][addr_a[0]]};
        cellc_a = mc[addr_a[1:0]];
        arr_a   = rd_a && (mat_a == MAT_A);
        brr_a   = rd_a && (mat_a == MAT_B) && (b_cnt >= b_delay);
        crr_a   = rd_a && (mat_a == MAT_C);
        rb_sel  = (addr_b == 8'd3);
        row_b   = {ma2[rb_sel][2], ma2[rb_sel][1], ma2[rb_sel][0]};
        colb_b  = {mb2[2][addr_b[0]], mb2[1][addr_b[0]], mb2[0][addr_b[0]]};
        cellc_b = 16'h0000;
        arr_b   = rd_b && (mat_b == MAT_A);
        brr_b   = rd_b && (mat_b == MAT_B);
        crr_b   = rd_b && (mat_b == MAT_C);
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        b_cnt <= (rd_a && (mat_a == MAT_B) && !brr_a) ? b_cnt + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: pop and compare on every write, check held B request
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wr_a) begin
            check("rw_excl_a", 32'(rd_a), 32'd0);
            check("sb_pending_a", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("wr_addr_a", 32'(addr_a), 32'(e.addr));
                check("wr_data_a", 32'(cout_a), 32'(e.data[7:0]));
            end
            wr_cnt_a++;
            wr_cyc.push_back(cyc);
        end
        if (!rst && wr_b) begin
            check("sb_pending_b", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("wr_addr_b", 32'(addr_b), 32'(e.addr));
                check("wr_data_b", 32'(cout_b), 32'(e.data));
            end
            wr_cnt_b++;
        end
        if (!rst && rd_a && (mat_a == MAT_B) && prev_b_wait)
            check("b_req_steady", 32'(addr_a), 32'(prev_b_addr));
        prev_b_wait <= rd_a && (mat_a == MAT_B) && !brr_a;
        prev_b_addr <= addr_a;
    end

    task automatic set_a(input int a00, input int a01, input int a10, input int a11);
        ma[0][0] = 8'(a00); ma[0][1] = 8'(a01); ma[1][0] = 8'(a10); ma[1][1] = 8'(a11);
    endtask

    // b00 = B[k=0][col 0], b01 = B[k=0][col 1], ...
    task automatic set_b(input int b00, input int b01, input int b10, input int b11);
        mb[0][0] = 8'(b00); mb[0][1] = 8'(b01); mb[1][0] = 8'(b10); mb[1][1] = 8'(b11);
    endtask

    task automatic set_c(input int v);
        for (int i = 0; i < 4; i++) mc[i] = 8'(v);
    endtask

    task automatic push_a(input int addr, input int data);
        exp_t e;
        e.addr = 8'(addr);
        e.data = 16'(data & 255);
        q_a.push_back(e);
    endtask

    // Reference model for instance A: C = seed + A*B, clamped or truncated
    task automatic push_model_a(input logic [1:0] m);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                int acc;
                acc = m[0] ? int'(mc[r*2+c]) : 0;
                for (int k = 0; k < 2; k++) acc += int'(ma[r][k]) * int'(mb[k][c]);
                if (m[1] && acc > 127) acc = 127;
                if (m[1] && acc < -128) acc = -128;
                push_a(r*2 + c, acc);
            end
        end
    endtask

    task automatic start_a(input logic [1:0] m);
        @(negedge clk);
        mode_a  = m;
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        mode_a  = ~m;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_a_reached", 32'(done_a), 32'd1);
    endtask

    task automatic ack_done_a();
        @(negedge clk);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        check("ready_clear_a", 32'(done_a), 32'd0);
        check("idle_busy_a", 32'(busy_a), 32'd0);
    endtask

    task automatic run_a(input logic [1:0] m, input string tag);
        int base;
        base = wr_cnt_a;
        wr_cyc.delete();
        start_a(m);
        wait_done_a(300);
        check({tag, "_writes"}, 32'(wr_cnt_a - base), 32'd4);
        check({tag, "_sb_empty"}, 32'(q_a.size()), 32'd0);
        check({tag, "_done_addr0"}, 32'(addr_a), 32'd0);
        ack_done_a();
    endtask

    initial begin
        rst = 1'b1;
        ready_a = 1'b0; ack_a = 1'b0; mode_a = 2'b00;
        ready_b = 1'b0; ack_b = 1'b0; mode_b = 2'b00;
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0); set_c(0);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++) ma2[r][k] = 16'(r*3 + k + 1);
        mb2[0][0] = 16'd7;  mb2[1][0] = 16'd9;  mb2[2][0] = 16'd11;
        mb2[0][1] = 16'd8;  mb2[1][1] = 16'd10; mb2[2][1] = 16'd12;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ready", 32'(done_a), 32'd0);
        check("rst_rd", 32'(rd_a), 32'd0);
        check("rst_wr", 32'(wr_a), 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_cell", 32'(cout_a), 32'd0);
        rst = 1'b0;

        // Test 1: A=[[1,2],[3,4]], B=I, plain multiply, plus cell timing
        set_a(1, 2, 3, 4); set_b(1, 0, 0, 1); set_c(0);
        push_a(0, 1); push_a(1, 2); push_a(2, 3); push_a(3, 4);
        run_a(2'b00, "t1");
        check("t1_cyc_count", 32'(wr_cyc.size()), 32'd4);
        if (wr_cyc.size() == 4) begin
            check("t1_cell_latency", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
            check("t1_row_latency", 32'(wr_cyc[2] - wr_cyc[1]), 32'd5);
        end

        // Accumulate onto preloaded 10s
        set_c(10);
        push_a(0, 11); push_a(1, 12); push_a(2, 13); push_a(3, 14);
        run_a(2'b01, "acc");
        if (wr_cyc.size() == 4)
            check("acc_cell_latency", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);

        // Full-scale cells: saturate then wrap
        set_a(127, 127, 127, 127); set_b(127, 127, 127, 127); set_c(0);
        for (int i = 0; i < 4; i++) push_a(i, 127);
        run_a(2'b10, "sat");
        for (int i = 0; i < 4; i++) push_a(i, 8'h02);
        run_a(2'b00, "wrap");

        // Mixed signs with accumulate and saturate, checked against the model
        set_a(-3, 5, 7, -8); set_b(2, -1, 4, 6); set_c(100);
        push_model_a(2'b11);
        run_a(2'b11, "mixed");

        // Slow B memory: same results, request held
        set_a(1, 2, 3, 4); set_b(1, 0, 0, 1); set_c(0);
        b_delay = 3;
        push_a(0, 1); push_a(1, 2); push_a(2, 3); push_a(3, 4);
        run_a(2'b00, "bwait");
        b_delay = 0;

        // Reset during MAC of cell (1,0)
        begin
            int base;
            int n;
            base = wr_cnt_a;
            n = 0;
            push_a(0, 1); push_a(1, 2);
            start_a(2'b00);
            while (wr_cnt_a < base + 2 && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("pre_rst_writes", 32'(wr_cnt_a - base), 32'd2);
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("in_mac_busy", 32'(busy_a), 32'd1);
            check("in_mac_rdwr", 32'({rd_a, wr_a}), 32'd0);
            rst = 1'b1;
            #1;
            check("mid_rst_busy", 32'(busy_a), 32'd0);
            check("mid_rst_outs", 32'({rd_a, wr_a, done_a, type_a, mat_a}), 32'd0);
            check("mid_rst_addr", 32'(addr_a), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            repeat (12) @(negedge clk);
            check("no_write_after_rst", 32'(wr_cnt_a - base), 32'd2);
            check("post_rst_idle", 32'(busy_a), 32'd0);
            push_a(0, 1); push_a(1, 2); push_a(2, 3); push_a(3, 4);
            run_a(2'b00, "restart");
        end

        // Instance B: 2x3 times 3x2
        begin
            exp_t e;
            int n;
            int expv[4];
            expv[0] = 58; expv[1] = 64; expv[2] = 139; expv[3] = 154;
            for (int i = 0; i < 4; i++) begin
                e.addr = 8'(i);
                e.data = 16'(expv[i]);
                q_b.push_back(e);
            end
            @(negedge clk);
            ready_b = 1'b1;
            @(negedge clk);
            ready_b = 1'b0;
            n = 0;
            while (!done_b && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("done_b_reached", 32'(done_b), 32'd1);
            check("b_writes", 32'(wr_cnt_b), 32'd4);
            check("b_sb_empty", 32'(q_b.size()), 32'd0);
            ack_b = 1'b1;
            @(negedge clk);
            ack_b = 1'b0;
            check("b_ready_clear", 32'(done_b), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
